// File: rtl/fixed_mult_arbiter.sv
// fixed_mult_arbiter: round-robin shared Q-format signed multiplier.
//
// NUM_REQ requesters compete for one 32x32 signed multiplier. The winner's
// operands are captured in an operand stage (S1); the next stage (S2) holds
// the scaled product, its overflow flag and the issuing requester id.
// Both ends use valid/ready; one multiply per cycle without backpressure.
//
// Optional build macro: FIXED_MULT_ARB_SAT_EN -- saturate res_p on overflow.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept (one-hot or zero, combinational)
//   req_a      operand A, requester i at [32*i+31:32*i], signed Q format
//   req_b      operand B, same packing
//   res_valid  result valid
//   res_ready  downstream accepts result
//   res_p      signed product, FRACT_BITS fractional bits
//   res_ovf    product did not fit in 32 bits
//   res_id     requester that issued the operation
//   busy       an operation is in S1 or S2
module fixed_mult_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FRACT_BITS = 16,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_p,
  output logic                    res_ovf,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  localparam int unsigned PROD_W = 64;
  localparam int unsigned MSB    = FRACT_BITS + 31;

  // Round-robin pointer: last granted requester
  logic [ID_W-1:0]    last;

  // Operand stage
  logic               s1_valid;
  logic signed [31:0] s1_a;
  logic signed [31:0] s1_b;
  logic [ID_W-1:0]    s1_id;

  // Combinational control
  logic [ID_W-1:0]    grant_c;
  logic [ID_W-1:0]    idx_c;
  logic               grant_found_c;
  logic               s2_free_c;
  logic               can_accept_c;
  logic               accept_c;
  logic               advance_c;
  logic [31:0]        a_sel_c;
  logic [31:0]        b_sel_c;

  // Datapath
  logic signed [PROD_W-1:0] full_c;
  logic [31:0]              p_c;
  logic                     ovf_c;
  logic                     unused_lsb_c;

  // Handshake conditions
  assign s2_free_c    = !res_valid || res_ready;
  assign advance_c    = s1_valid && s2_free_c;
  assign can_accept_c = !s1_valid || s2_free_c;
  assign accept_c     = grant_found_c && can_accept_c;
  assign busy         = s1_valid || res_valid;

  // Round-robin search starting just after the last winner
  always_comb begin
    grant_found_c = 1'b0;
    grant_c       = '0;
    idx_c         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = ID_W'((32'(last) + k) % NUM_REQ);
      if (!grant_found_c && req_valid[idx_c]) begin
        grant_found_c = 1'b1;
        grant_c       = idx_c;
      end
    end
  end

  // Ready to the winner only, and operand mux
  always_comb begin
    req_ready = '0;
    a_sel_c   = '0;
    b_sel_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c == ID_W'(i)) begin
        req_ready[i] = accept_c;
        a_sel_c      = req_a[32*i +: 32];
        b_sel_c      = req_b[32*i +: 32];
      end
    end
  end

  // Full product, scaled slice and overflow detection
  always_comb begin
    full_c = PROD_W'(s1_a) * PROD_W'(s1_b);
    p_c    = full_c[MSB:FRACT_BITS];
    // Upper bits must all equal the result sign bit
    ovf_c  = !((&full_c[PROD_W-1:MSB]) || !(|full_c[PROD_W-1:MSB]));
`ifdef FIXED_MULT_ARB_SAT_EN
    if (ovf_c) begin
      p_c = full_c[PROD_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
  end

  // Discarded fraction bits below the result LSB
  assign unused_lsb_c = ^full_c[FRACT_BITS-1:0];

  // Pipeline and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= ID_W'(NUM_REQ - 1);
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      res_valid <= 1'b0;
      res_p     <= '0;
      res_ovf   <= 1'b0;
      res_id    <= '0;
    end else begin
      if (accept_c) begin
        s1_valid <= 1'b1;
        s1_a     <= a_sel_c;
        s1_b     <= b_sel_c;
        s1_id    <= grant_c;
        last     <= grant_c;
      end else if (advance_c) begin
        s1_valid <= 1'b0;
      end

      if (advance_c) begin
        res_valid <= 1'b1;
        res_p     <= p_c;
        res_ovf   <= ovf_c;
        res_id    <= s1_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
